spi_cmd_slave: RTL and testbench

//  SPI mode-0 slave front end that feeds the register interface's host-access port.

---
 rtl/spi_cmd_slave.sv | 208 ++++++++++++++++++++
 tb/tb_spi_cmd_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 command slave for the register host-access port.
// Oversamples SCLK/MOSI/SS in the core clock domain and decodes
// {RW, reserved, addr, data} frames, MSB first.
// It issues single-cycle write/read strobes and returns read data
// serially on MISO in the data phase of the same frame.
module spi_cmd_slave #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              SS,
  output logic              MISO,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              frame_err,
  output logic              busy
);

  localparam int HDR_BITS = 2 + ADDR_W;
  localparam int FL       = HDR_BITS + DATA_W;
  // The receive shifter only ever needs to hold the header or the data field.
  localparam int SR_W     = (HDR_BITS > DATA_W) ? HDR_BITS : DATA_W;
  localparam int CNT_W    = $clog2(FL + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_s, mosi_s, ss_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic                   mosi_bit, sample_en, frame_bad;

  logic [CNT_W-1:0]       bit_cnt;
  logic [SR_W-1:0]        rx_sr;
  logic [DATA_W-1:0]      tx_sr;
  logic                   rw_q;
  logic [READ_LAT-1:0]    rd_vld_p;
  logic                   rd_capture;

  logic                   hdr_done, rd_d, wr_d, err_d;

  // ---- input synchronisers ----
  // Pins pass through SYNC_STAGES flops; idle state is SCLK=0, MOSI=0, SS=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s <= '0;
      mosi_s <= '0;
      ss_s   <= '1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], SCLK};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], MOSI};
      ss_s   <= {ss_s[SYNC_STAGES-2:0], SS};
    end
  end

  // Edges come from the last two synchroniser stages.
  assign sclk_rise = sclk_s[SYNC_STAGES-2] & ~sclk_s[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_s[SYNC_STAGES-2] & sclk_s[SYNC_STAGES-1];
  assign ss_rise   = ss_s[SYNC_STAGES-2] & ~ss_s[SYNC_STAGES-1];
  assign ss_fall   = ~ss_s[SYNC_STAGES-2] & ss_s[SYNC_STAGES-1];
  assign mosi_bit  = mosi_s[SYNC_STAGES-1];

  // SCLK activity counts only inside a frame; the SS-rise cycle closes the frame.
  assign sample_en = sclk_rise && (state_q != IDLE) && !ss_rise;
  assign frame_bad = (bit_cnt != '0) && (bit_cnt != CNT_W'(FL));

  // ---- frame FSM ----
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus strobe requests.
  // An SS rise always wins and closes the frame.
  always_comb begin
    state_d  = state_q;
    hdr_done = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) state_d = HDR;
      end
      HDR: begin
        if (ss_rise) begin
          state_d = IDLE;
          err_d   = frame_bad;
        end else if (bit_cnt == CNT_W'(HDR_BITS)) begin
          state_d  = DATA;
          hdr_done = 1'b1;
          rd_d     = ~rx_sr[HDR_BITS-1];
        end
      end
      DATA: begin
        if (ss_rise) begin
          state_d = IDLE;
          err_d   = frame_bad;
        end else if (bit_cnt == CNT_W'(FL)) begin
          state_d = DONE;
          wr_d    = rw_q;
        end
      end
      DONE: begin
        if (ss_rise) begin
          state_d = IDLE;
          err_d   = frame_bad;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- receive path ----
  // Bit counter is cleared between frames and saturates one past a full frame,
  // so overlong frames remain distinguishable from complete ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (state_q == IDLE || ss_rise) begin
      bit_cnt <= '0;
    end else if (sample_en && bit_cnt != CNT_W'(FL + 1)) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // The receive shifter is data only.
  // It is fully refilled before any field is taken from it.
  always_ff @(posedge clk) begin
    if (sample_en) rx_sr <= {rx_sr[SR_W-2:0], mosi_bit};
  end

  // The frame direction is latched at header completion.
  // It steers MISO and the write strobe for the rest of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rw_q <= 1'b0;
    else if (hdr_done) rw_q <= rx_sr[HDR_BITS-1];
  end

  // ---- register-port outputs ----
  // Strobes are registered and last one cycle.
  // addr updates at every completed header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      frame_err  <= 1'b0;
      addr       <= '0;
      write_data <= '0;
    end else begin
      wr_en     <= wr_d;
      rd_en     <= rd_d;
      frame_err <= err_d;
      if (hdr_done) addr <= rx_sr[ADDR_W-1:0];
      if (wr_d)     write_data <= rx_sr[DATA_W-1:0];
    end
  end

  assign busy = (state_q != IDLE);

  // ---- read return path ----
  // Delay line marks the cycle READ_LAT after rd_en when read_data is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p <= '0;
    end else begin
      rd_vld_p[0] <= rd_en;
      for (int i = 1; i < READ_LAT; i++) rd_vld_p[i] <= rd_vld_p[i-1];
    end
  end

  assign rd_capture = rd_vld_p[READ_LAT-1];

  // The transmit shifter loads the read word.
  // It then moves one bit per SCLK fall during a read data phase.
  always_ff @(posedge clk) begin
    if (rd_capture)
      tx_sr <= read_data;
    else if (sclk_fall && state_q == DATA && !rw_q && !ss_rise)
      tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
  end

  // MISO presents the next read bit on each SCLK fall, in read frames only.
  // It is held low in IDLE and HDR and is cleared when SS rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      MISO <= 1'b0;
    else if (state_q == IDLE || state_q == HDR || ss_rise)
      MISO <= 1'b0;
    else if (state_q == DATA && sclk_fall && !rw_q)
      MISO <= tx_sr[DATA_W-1];
  end

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Bench for spi_cmd_slave: directed frames plus randomized write/read-back
// pairs, with a simple register-file peripheral on the host-access port.
module tb_spi_cmd_slave;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        SS   = 1'b1;
  logic        MISO, wr_en, rd_en, frame_err, busy;
  logic [13:0] addr;
  logic [15:0] write_data;
  logic [15:0] read_data = 16'h0;

  int n_total = 0;
  int n_pass  = 0;

  int          wr_cnt, rd_cnt, err_cnt;
  int          both_cnt = 0;
  logic [13:0] last_wr_addr, last_rd_addr;
  logic [15:0] last_wr_data;

  logic [15:0] regfile [0:16383];
  logic [15:0] exp_mem [int];
  bit          rd_hold = 1'b0;
  logic [13:0] rd_addr_q;

  spi_cmd_slave dut (
    .clk        (clk),
    .rst        (rst),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .SS         (SS),
    .MISO       (MISO),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Register-file peripheral: records strobes.
  // read_data is valid only in the single cycle one clock after rd_en and carries garbage otherwise.
  always @(negedge clk) begin
    if (rd_hold) begin
      read_data = regfile[rd_addr_q];
      rd_hold   = 1'b0;
    end else begin
      read_data = 16'($urandom);
    end
    if (rd_en) begin
      rd_cnt++;
      last_rd_addr = addr;
      rd_addr_q    = addr;
      rd_hold      = 1'b1;
    end
    if (wr_en) begin
      wr_cnt++;
      last_wr_addr     = addr;
      last_wr_data     = write_data;
      regfile[addr]    = write_data;
    end
    if (frame_err)      err_cnt++;
    if (wr_en && rd_en) both_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    wr_cnt  = 0;
    rd_cnt  = 0;
    err_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk_frame(input logic rw, input logic res,
                                           input logic [13:0] a, input logic [15:0] d);
    return {rw, res, a, d};
  endfunction

  // Mode-0 master: MOSI changes while SCLK is low; MISO is read on SCLK rise.
  // Sends the low nbits of 'bits' MSB first. rword collects MISO at rises 17..32.
  task automatic spi_xfer(input logic [39:0] bits, input int nbits, input int hp,
                          input bit end_ss, output logic [15:0] rword,
                          output bit miso_hi, output bit hdr_hi);
    int bitno;
    rword   = '0;
    miso_hi = 1'b0;
    hdr_hi  = 1'b0;
    SS = 1'b0;
    wait_clk(hp);
    for (int i = nbits - 1; i >= 0; i--) begin
      bitno = nbits - i;
      MOSI  = bits[i];
      wait_clk(hp);
      SCLK = 1'b1;
      if (MISO) miso_hi = 1'b1;
      if (bitno <= 16 && MISO) hdr_hi = 1'b1;
      if (bitno >= 17 && bitno <= 32) rword = {rword[14:0], MISO};
      wait_clk(hp);
      SCLK = 1'b0;
    end
    if (end_ss) begin
      wait_clk(hp);
      SS   = 1'b1;
      MOSI = 1'b0;
      wait_clk(8);
    end
  endtask

  initial begin
    logic [31:0] f;
    logic [15:0] w, d;
    logic [13:0] a;
    bit          mh, hh, miso_any, busy_any;

    // Reset state
    rst = 1'b1;
    wait_clk(3);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", 32'(write_data), 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // Write frame 0x8001_ABCD at SCLK = clk/8
    clr_mon();
    spi_xfer({8'h00, 32'h8001_ABCD}, 32, 4, 1'b1, w, mh, hh);
    chk("w1_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("w1_addr", 32'(last_wr_addr), 32'h0001);
    chk("w1_data", 32'(last_wr_data), 32'hABCD);
    chk("w1_miso_low", 32'(mh), 32'd0);
    chk("w1_err", 32'(err_cnt), 32'd0);
    chk("w1_rd_cnt", 32'(rd_cnt), 32'd0);

    // Read frame for addr 0x1234, peripheral returns 0x5A5A
    regfile[14'h1234] = 16'h5A5A;
    clr_mon();
    f = mk_frame(1'b0, 1'b1, 14'h1234, 16'hFFFF);
    spi_xfer({8'h00, f}, 32, 6, 1'b1, w, mh, hh);
    chk("r1_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("r1_rd_addr", 32'(last_rd_addr), 32'h1234);
    chk("r1_miso_word", 32'(w), 32'h5A5A);
    chk("r1_hdr_miso_low", 32'(hh), 32'd0);
    chk("r1_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("r1_err", 32'(err_cnt), 32'd0);
    chk("r1_addr_held", 32'(addr), 32'h1234);

    // Short write frame: SS rises after 20 bits
    clr_mon();
    f = mk_frame(1'b1, 1'b0, 14'h0155, 16'h2468);
    spi_xfer(40'(f >> 12), 20, 6, 1'b1, w, mh, hh);
    chk("short_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("short_err", 32'(err_cnt), 32'd1);
    chk("short_busy", 32'(busy), 32'd0);

    // 33-bit write frame
    clr_mon();
    f = mk_frame(1'b1, 1'b0, 14'h2AAA, 16'hC3C3);
    spi_xfer({7'h00, f, 1'b1}, 33, 6, 1'b1, w, mh, hh);
    chk("long_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("long_addr", 32'(last_wr_addr), 32'h2AAA);
    chk("long_data", 32'(last_wr_data), 32'hC3C3);
    chk("long_err", 32'(err_cnt), 32'd1);

    // SCLK/MOSI toggling with SS high
    clr_mon();
    miso_any = 1'b0;
    busy_any = 1'b0;
    for (int i = 0; i < 40; i++) begin
      MOSI = 1'($urandom);
      SCLK = ~SCLK;
      wait_clk(3);
      if (MISO) miso_any = 1'b1;
      if (busy) busy_any = 1'b1;
    end
    SCLK = 1'b0;
    wait_clk(4);
    chk("idle_strobes", 32'(wr_cnt + rd_cnt + err_cnt), 32'd0);
    chk("idle_miso", 32'(miso_any), 32'd0);
    chk("idle_busy", 32'(busy_any), 32'd0);

    // Reset in the middle of a read frame (after bit 24)
    clr_mon();
    f = mk_frame(1'b0, 1'b0, 14'h0777, 16'h0000);
    spi_xfer(40'(f >> 8), 24, 6, 1'b0, w, mh, hh);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_outputs", {25'd0, wr_en, rd_en, frame_err, busy, MISO, 2'b00}, 32'd0);
    chk("mrst_addr", 32'(addr), 32'd0);
    chk("mrst_wdata", 32'(write_data), 32'd0);
    SS   = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    clr_mon();
    f = mk_frame(1'b1, 1'b0, 14'h0ABC, 16'h1357);
    spi_xfer({8'h00, f}, 32, 6, 1'b1, w, mh, hh);
    chk("post_rst_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("post_rst_wdata", 32'(last_wr_data), 32'h1357);
    chk("post_rst_waddr", 32'(last_wr_addr), 32'h0ABC);
    f = mk_frame(1'b0, 1'b0, 14'h0ABC, 16'h0000);
    spi_xfer({8'h00, f}, 32, 6, 1'b1, w, mh, hh);
    chk("post_rst_rword", 32'(w), 32'h1357);
    chk("post_rst_err", 32'(err_cnt), 32'd0);

    // Randomized write / read-back pairs against the expected register contents
    for (int k = 0; k < 6; k++) begin
      a = 14'($urandom_range(0, 16383));
      d = 16'($urandom);
      clr_mon();
      f = mk_frame(1'b1, 1'($urandom), a, d);
      spi_xfer({8'h00, f}, 32, 6, 1'b1, w, mh, hh);
      exp_mem[int'(a)] = d;
      chk("rnd_wr_cnt", 32'(wr_cnt), 32'd1);
      chk("rnd_wr_data", 32'(last_wr_data), 32'(d));
      chk("rnd_wr_addr", 32'(last_wr_addr), 32'(a));
      f = mk_frame(1'b0, 1'($urandom), a, 16'($urandom));
      spi_xfer({8'h00, f}, 32, 6, 1'b1, w, mh, hh);
      chk("rnd_rd_cnt", 32'(rd_cnt), 32'd1);
      chk("rnd_rword", 32'(w), 32'(exp_mem[int'(a)]));
      chk("rnd_err", 32'(err_cnt), 32'd0);
    end

    chk("no_dual_strobe", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
